// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - width helpers, reset constants and parameter checks for sync_fifo
package sync_fifo_pkg;

    localparam logic RD_DATA_RST_BIT  = 1'b0;
    localparam logic RD_VALID_RST     = 1'b0;
    localparam logic OVERFLOW_RST     = 1'b0;
    localparam logic UNDERFLOW_RST    = 1'b0;

    // Pointer width; a depth of one would give $clog2 == 0, so floor it at one bit.
    function automatic int ptr_t(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count must represent 0..DEPTH inclusive.
    function automatic int cnt_t(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int depth, input int af_thresh,
                                     input int ae_thresh);
        return is_pow2(depth) && (ae_thresh < af_thresh) && (af_thresh <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - DEPTH x WIDTH register array, one write port, one registered read port
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ptr_t(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    input  logic [ptr_t(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are never cleared; reset only makes them unreachable via the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= {WIDTH{RD_DATA_RST_BIT}};
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parametrised single-clock FIFO with flags, count and optional SYNC_FIFO_ERR_EN error flags
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_t(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = ptr_t(DEPTH);
    localparam int CW = cnt_t(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $fatal(1, "sync_fifo: DEPTH must be a power of two >= 2 and AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign push = wr_en && (!full || rd_en) && !reset;
    assign pop  = rd_en && !empty && !reset;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= RD_VALID_RST;
        end else begin
            rd_valid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= OVERFLOW_RST;
            underflow <= UNDERFLOW_RST;
        end else begin
            if (wr_en && full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo #(
        .WIDTH     (8),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic flags(input string tag, input logic [3:0] c, input logic f, input logic e,
                         input logic af, input logic ae);
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_full"}, 32'(full), 32'(f));
        chk({tag, "_empty"}, 32'(empty), 32'(e));
        chk({tag, "_af"}, 32'(almost_full), 32'(af));
        chk({tag, "_ae"}, 32'(almost_empty), 32'(ae));
    endtask

    initial begin
        // 1. reset values
        repeat (2) @(posedge clk);
        #1;
        flags("rst", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        reset = 1'b0;

        // 2. fill, overflow, drain
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'(8'h10 + i), 1'b0);
            flags("fill", 4'(i + 1), (i == 7), 1'b0, (i >= 5), (i <= 1));
        end
        cyc(1'b1, 8'h18, 1'b0);
        flags("ovf", 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'(ERR));
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_valid", 32'(rd_valid), 32'd1);
            chk("drain_data", 32'(rd_data), 32'(8'h10 + i));
            chk("drain_count", 32'(count), 32'(7 - i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_unf", 32'(underflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("unf_valid", 32'(rd_valid), 32'd0);
        chk("unf_hold", 32'(rd_data), 32'h17);
        chk("unf_flag", 32'(underflow), 32'(ERR));

        // 3. wrap-around: pointers sit at 5 before the 7-word burst
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 1), 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("pre_data", 32'(rd_data), 32'(i + 1));
        end
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 8'(8'hA0 + i), 1'b0);
            chk("wrap_count", 32'(count), 32'(i + 1));
        end
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("wrap_valid", 32'(rd_valid), 32'd1);
            chk("wrap_data", 32'(rd_data), 32'(8'hA0 + i));
            chk("wrap_count_dn", 32'(count), 32'(6 - i));
        end

        // 4. simultaneous push/pop while full, with sticky flags cleared first
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_unf", 32'(underflow), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
        cyc(1'b1, 8'h55, 1'b1);
        chk("fullrw_valid", 32'(rd_valid), 32'd1);
        chk("fullrw_data", 32'(rd_data), 32'h20);
        flags("fullrw", 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("fullrw_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("fullrw_drain", 32'(rd_data), (i == 7) ? 32'h55 : 32'(8'h21 + i));
        end
        chk("fullrw_empty", 32'(empty), 32'd1);

        // 5. simultaneous request while empty
        cyc(1'b1, 8'h33, 1'b1);
        chk("emptyrw_valid", 32'(rd_valid), 32'd0);
        chk("emptyrw_count", 32'(count), 32'd1);
        chk("emptyrw_unf", 32'(underflow), 32'(ERR));
        cyc(1'b0, 8'h00, 1'b1);
        chk("emptyrw_valid2", 32'(rd_valid), 32'd1);
        chk("emptyrw_data", 32'(rd_data), 32'h33);

        // 6. reset mid-operation with both requests active
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
        chk("mid_count", 32'(count), 32'd4);
        reset = 1'b1;
        cyc(1'b1, 8'h99, 1'b1);
        reset = 1'b0;
        flags("midrst", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("midrst_valid", 32'(rd_valid), 32'd0);
        chk("midrst_data", 32'(rd_data), 32'h00);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_unf", 32'(underflow), 32'd0);
        cyc(1'b1, 8'h77, 1'b0);
        chk("post_count", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_valid", 32'(rd_valid), 32'd1);
        chk("post_data", 32'(rd_data), 32'h77);
        chk("post_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO. It replaces the fixed 8x8 buffer in the component library with configurable width and depth. It adds full/empty and almost-full/almost-empty flags, an occupancy count, and correct simultaneous read/write handling. It sits between a producer and a consumer in the same clock domain and is the standard buffering primitive for later library blocks.

## Interface
- `WIDTH`, default 8: data word width in bits, ≥1.
- `DEPTH`, default 8: number of entries. Must be a power of two, ≥2.
- `AF_THRESH`, default `DEPTH-2`: `almost_full` asserts when `count >= AF_THRESH`.
- `AE_THRESH`, default 2: `almost_empty` asserts when `count <= AE_THRESH`.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: reset, synchronous, active-high; clock `clk`.
- `wr_en`, input, 1: push request.
- `wr_data`, input, `WIDTH`: word to push.
- `rd_en`, input, 1: pop request.
- `rd_data`, output, `WIDTH`: popped word, registered.
- `rd_valid`, output, 1: one-cycle pulse; `rd_data` is valid.
- `full`, output, 1: `count == DEPTH`.
- `empty`, output, 1: `count == 0`.
- `almost_full`, output, 1: threshold flag.
- `almost_empty`, output, 1: threshold flag.
- `count`, output, `$clog2(DEPTH+1)`: current occupancy.
- `overflow`, output, 1: sticky; a push was rejected (see Configuration).
- `underflow`, output, 1: sticky; a pop was rejected (see Configuration).

## Operation
- **Storage and pointers.** Storage is `DEPTH` x `WIDTH` registers. `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits wide and wrap naturally from `DEPTH-1` to 0.
- **Accepted push:** `push = wr_en && (!full || rd_en)`. The word is written at `wr_ptr`, then `wr_ptr` increments.
- **Accepted pop:** `pop = rd_en && !empty`. The word at `rd_ptr` is registered into `rd_data`, `rd_valid` is set to 1, then `rd_ptr` increments.
- **Count update:**
  - `push` and `pop` together: `count` is unchanged.
  - `push` only: `count + 1`.
  - `pop` only: `count - 1`.
- **Full with simultaneous request:** `wr_en && rd_en` while full → both are accepted and `count` stays `DEPTH`.
- **Empty with simultaneous request:** `wr_en && rd_en` while empty → only the push is accepted. There is no bypass. `rd_valid` stays 0 and `underflow` is set.
- **Rejected requests leave state untouched:**
  - Push while full without a pop: memory, `wr_ptr` and `count` are unchanged.
  - Pop while empty: `rd_data` holds its last value and `rd_valid` is 0.
- **Flag derivation.** `full`, `empty`, `almost_full` and `almost_empty` are combinational decodes of the registered `count`, so there are no independent flag registers.
- **Reset.** Reset takes priority over every request, including reset asserted mid-transfer. All requests in that cycle are dropped. Stored words are not cleared; they are unreachable once the pointers reset.
- **Output values under reset:**
  - `rd_data = 0`, `rd_valid = 0`, `count = 0`.
  - `empty = 1`, `full = 0`.
  - `almost_empty = 1`, `almost_full = 0`.
  - `overflow = 0`, `underflow = 0`.
  - Pointers are 0.

## Timing
- **Write-to-read latency.** A word pushed at edge N can be popped by `rd_en` sampled at edge N+1. The data then appears on `rd_data` after edge N+1.
- **Read latency** is 1 cycle. `rd_en` is sampled at edge N, and `rd_data`/`rd_valid` are valid between edges N and N+1.
- **Flag and count timing.** Flags and `count` reflect all operations accepted at the most recent edge. There is no extra lag.
- **Back-to-back streaming.** Continuous `wr_en` and `rd_en` give one push and one pop per cycle with no bubbles.

## Configuration
- Macro: `SYNC_FIFO_ERR_EN`.
- **Defined:**
  - `overflow` sets on any cycle with `wr_en && full && !rd_en`.
  - `underflow` sets on any cycle with `rd_en && empty`.
  - Both remain 1 until `reset`.
- **Undefined:** both ports remain in the port list and are tied to 0, with no logic generated.

## Structure
- Package `sync_fifo_pkg` holds:
  - the `ptr_t` and `cnt_t` width helper functions (`$clog2`-based);
  - the reset constants for `rd_data` and the flags;
  - elaboration-time checks: `DEPTH` is a power of two, and `AE_THRESH < AF_THRESH <= DEPTH`.
- One sub-module, `sync_fifo_mem`: the `DEPTH` x `WIDTH` register array with one write port and one registered read port.
- Pointer, count, flag and error logic live in `sync_fifo`.

## Test plan
All scenarios use `WIDTH=8`, `DEPTH=8`, `AF_THRESH=6`, `AE_THRESH=2`, with `SYNC_FIFO_ERR_EN` defined.
1. **Reset values.** Apply reset for 2 cycles → `empty=1`, `almost_empty=1`, `count=0`, `rd_valid=0`, `rd_data=0x00`, `overflow=0`, `underflow=0`.
2. **Fill and overflow.** Push 0x10..0x17 → `count=8`, `full=1`, `almost_full` set from `count=6`. A 9th push of 0x18 is dropped and `overflow=1`. Then pop 8 → `rd_data` sequence 0x10..0x17, each with `rd_valid=1`, ending with `empty=1`.
3. **Pointer wrap-around.** Push 5, pop 5, then push 0xA0..0xA6 → the pointers wrap, the data pops out in order, and `count` tracks exactly.
4. **Simultaneous push and pop when full.** With `count=8`, drive `wr_en`, `rd_en` and `wr_data=0x55` → the oldest word is popped, `count` stays 8, `full` stays 1, and `overflow` does not set.
5. **Simultaneous request and pop when empty.** With `count=0`, drive `wr_en`, `rd_en` and `wr_data=0x33` → `rd_valid=0`, `count=1`, `underflow=1`. A pop on the next cycle returns 0x33.
6. **Mid-operation reset.** With `count=4` and `wr_en` + `rd_en` active, assert reset for one cycle → `count=0`, `empty=1`, `rd_valid=0`, and `overflow`/`underflow` cleared. A following push then pop of 0x77 returns 0x77.
